// File: rtl/tick_down_timer.sv
// Loadable down-counting timer: counts tick_i pulses from a programmed load down to zero and pulses done_o.
// Optional build macro TICK_DOWN_TIMER_AUTO_RELOAD_EN: expiry reloads from the reload register and keeps running.
module tick_down_timer #(
    parameter int unsigned WIDTH    = 7,
    parameter int unsigned MIN_LOAD = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] LP_MIN = WIDTH'(MIN_LOAD);
    localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

    logic             r_state;
    logic             w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_load_zero;
    logic [WIDTH-1:0] w_load_eff;

`ifdef TICK_DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
`endif

    assign w_load_zero = (load_val_i == '0);
    assign w_load_eff  = (load_val_i < LP_MIN) ? LP_MIN : load_val_i;

    // start_i is handled identically in IDLE and RUN, so it is decoded ahead of the state;
    // stop_i outranks it, and a start discards any coincident tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_done_nxt   = 1'b0;
`ifdef TICK_DOWN_TIMER_AUTO_RELOAD_EN
        w_reload_nxt = r_reload;
`endif
        if (!stop_i && start_i) begin
            if (w_load_zero) begin
                w_count_nxt = '0;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end else begin
                w_count_nxt  = w_load_eff;
                w_state_nxt  = ST_RUN;
`ifdef TICK_DOWN_TIMER_AUTO_RELOAD_EN
                w_reload_nxt = w_load_eff;
`endif
            end
        end else if (r_state == ST_RUN) begin
            if (stop_i) begin
                w_state_nxt = ST_IDLE;
            end else if (tick_i) begin
                if (r_count > LP_ONE) begin
                    w_count_nxt = r_count - LP_ONE;
                end else if (r_count == LP_ONE) begin
                    w_done_nxt  = 1'b1;
`ifdef TICK_DOWN_TIMER_AUTO_RELOAD_EN
                    w_count_nxt = r_reload;
`else
                    w_count_nxt = '0;
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef TICK_DOWN_TIMER_AUTO_RELOAD_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_reload <= '0;
        end else begin
            r_reload <= w_reload_nxt;
        end
    end
`endif

    assign count_o = r_count;
    assign busy_o  = (r_state == ST_RUN);
    assign done_o  = r_done;

endmodule

// File: tb/tb_tick_down_timer.sv
// Scoreboard bench for tick_down_timer: each driven cycle pushes its expected outputs,
// which are popped and compared one cycle later, #1 after the sampling edge.
module tb_tick_down_timer;

    logic       clk;
    logic       rst_n;
    logic       tick_i;
    logic       start_i;
    logic       stop_i;
    logic [6:0] load_val_i;
    logic [6:0] count_o;
    logic       busy_o;
    logic       done_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       st;
        logic       sp;
        logic       tk;
        logic [6:0] ld;
        logic [6:0] ec;
        logic       eb;
        logic       ed;
    } vec_t;

    typedef struct packed {
        logic [6:0] c;
        logic       b;
        logic       d;
    } exp_t;

    exp_t sb[$];

    tick_down_timer #(
        .WIDTH    (7),
        .MIN_LOAD (1)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .tick_i     (tick_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .load_val_i (load_val_i),
        .count_o    (count_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int st, int sp, int tk, int ld, int ec, int eb, int ed);
        vec_t v;
        v.st = st[0];
        v.sp = sp[0];
        v.tk = tk[0];
        v.ld = ld[6:0];
        v.ec = ec[6:0];
        v.eb = eb[0];
        v.ed = ed[0];
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        start_i    = v.st;
        stop_i     = v.sp;
        tick_i     = v.tk;
        load_val_i = v.ld;
        e.c = v.ec;
        e.b = v.eb;
        e.d = v.ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        vec_t v[$];
        rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; tick_i = 1'b1; load_val_i = 7'd9;
        @(posedge clk);
        #1;
        sb.push_back('0);
        e = sb.pop_front();
        checks++;
        if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
            failures++;
            $display("FAIL reset got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", count_o, busy_o, done_o, e.c, e.b, e.d);
        end
        #3 rst_n = 1'b1;
        v.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            apply(v[i]);
            e = sb.pop_front();
            checks++;
            if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
                failures++;
                $display("FAIL idle[%0d] got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", i, count_o, busy_o, done_o, e.c, e.b, e.d);
            end
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   n;
        for (int i = 0; i <= 22; i++) begin
            n = (i / 4 > 5) ? 5 : i / 4;
            apply(mk(i == 0, 0, (i > 0) && (i % 4 == 0) && (i <= 20), 5, 5 - n, n < 5, i == 20));
            e = sb.pop_front();
            checks++;
            if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
                failures++;
                $display("FAIL basic[%0d] got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", i, count_o, busy_o, done_o, e.c, e.b, e.d);
            end
        end
    endtask

    task automatic test_zero();
        exp_t e;
        vec_t v[$];
        v.push_back(mk(1, 0, 0, 0, 0, 0, 1));
        v.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        foreach (v[i]) begin
            apply(v[i]);
            e = sb.pop_front();
            checks++;
            if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
                failures++;
                $display("FAIL zero[%0d] got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", i, count_o, busy_o, done_o, e.c, e.b, e.d);
            end
        end
    endtask

    task automatic test_stop();
        exp_t e;
        vec_t v[$];
        v.push_back(mk(1, 0, 0, 3, 3, 1, 0));
        v.push_back(mk(0, 0, 1, 0, 2, 1, 0));
        v.push_back(mk(0, 1, 1, 0, 2, 0, 0));
        v.push_back(mk(0, 0, 1, 0, 2, 0, 0));
        v.push_back(mk(0, 0, 1, 0, 2, 0, 0));
        v.push_back(mk(0, 0, 1, 0, 2, 0, 0));
        foreach (v[i]) begin
            apply(v[i]);
            e = sb.pop_front();
            checks++;
            if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
                failures++;
                $display("FAIL stop[%0d] got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", i, count_o, busy_o, done_o, e.c, e.b, e.d);
            end
        end
    endtask

    task automatic test_restart();
        exp_t e;
        vec_t v[$];
        v.push_back(mk(1, 0, 0, 4, 4, 1, 0));
        v.push_back(mk(0, 0, 1, 0, 3, 1, 0));
        v.push_back(mk(0, 0, 1, 0, 2, 1, 0));
        v.push_back(mk(1, 0, 1, 6, 6, 1, 0));
        for (int k = 1; k <= 6; k++) begin
            v.push_back(mk(0, 0, 0, 0, 7 - k, 1, 0));
            v.push_back(mk(0, 0, 1, 0, 6 - k, k < 6, k == 6));
        end
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            apply(v[i]);
            e = sb.pop_front();
            checks++;
            if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
                failures++;
                $display("FAIL restart[%0d] got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", i, count_o, busy_o, done_o, e.c, e.b, e.d);
            end
        end
    endtask

    task automatic test_continuous();
        exp_t e;
        for (int k = 0; k <= 129; k++) begin
            if (k == 0)
                apply(mk(1, 0, 0, 127, 127, 1, 0));
            else if (k <= 127)
                apply(mk(0, 0, 1, 0, 127 - k, k < 127, k == 127));
            else
                apply(mk(0, 0, 1, 0, 0, 0, 0));
            e = sb.pop_front();
            checks++;
            if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
                failures++;
                $display("FAIL cont[%0d] got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", k, count_o, busy_o, done_o, e.c, e.b, e.d);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        vec_t v[$];
        v.push_back(mk(1, 0, 0, 2, 2, 1, 0));
        v.push_back(mk(0, 0, 1, 0, 1, 1, 0));
        v.push_back(mk(0, 0, 1, 0, 0, 0, 1));
        v.push_back(mk(1, 0, 0, 3, 3, 1, 0));
        v.push_back(mk(0, 0, 1, 0, 2, 1, 0));
        v.push_back(mk(1, 0, 1, 0, 0, 0, 1));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 1));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1, 1, 0, 4, 0, 0, 0));
        foreach (v[i]) begin
            apply(v[i]);
            e = sb.pop_front();
            checks++;
            if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
                failures++;
                $display("FAIL b2b[%0d] got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", i, count_o, busy_o, done_o, e.c, e.b, e.d);
            end
        end
    endtask

`ifdef TICK_DOWN_TIMER_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        exp_t e;
        int   r;
        for (int k = 0; k <= 10; k++) begin
            r = k % 3;
            if (k == 0)
                apply(mk(1, 0, 0, 3, 3, 1, 0));
            else if (k <= 9)
                apply(mk(0, 0, 1, 0, (r == 0) ? 3 : 3 - r, 1, r == 0));
            else
                apply(mk(0, 1, 1, 0, 3, 0, 0));
            e = sb.pop_front();
            checks++;
            if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
                failures++;
                $display("FAIL reload[%0d] got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", k, count_o, busy_o, done_o, e.c, e.b, e.d);
            end
        end
    endtask
`endif

    task automatic test_async_reset();
        exp_t e;
        apply(mk(1, 0, 0, 5, 5, 1, 0));
        e = sb.pop_front();
        checks++;
        if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
            failures++;
            $display("FAIL arst_load got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", count_o, busy_o, done_o, e.c, e.b, e.d);
        end
        apply(mk(0, 0, 1, 0, 4, 1, 0));
        e = sb.pop_front();
        checks++;
        if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
            failures++;
            $display("FAIL arst_tick got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", count_o, busy_o, done_o, e.c, e.b, e.d);
        end
        #2 rst_n = 1'b0;
        #1;
        sb.push_back('0);
        e = sb.pop_front();
        checks++;
        if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
            failures++;
            $display("FAIL arst_async got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", count_o, busy_o, done_o, e.c, e.b, e.d);
        end
        apply(mk(0, 0, 1, 0, 0, 0, 0));
        e = sb.pop_front();
        checks++;
        if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
            failures++;
            $display("FAIL arst_held got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", count_o, busy_o, done_o, e.c, e.b, e.d);
        end
        #2 rst_n = 1'b1;
        apply(mk(0, 0, 1, 0, 0, 0, 0));
        e = sb.pop_front();
        checks++;
        if ({count_o, busy_o, done_o} !== {e.c, e.b, e.d}) begin
            failures++;
            $display("FAIL arst_after got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b", count_o, busy_o, done_o, e.c, e.b, e.d);
        end
    endtask

    initial begin
        test_reset();
`ifdef TICK_DOWN_TIMER_AUTO_RELOAD_EN
        test_zero();
        test_stop();
        test_auto_reload();
`else
        test_basic();
        test_zero();
        test_stop();
        test_restart();
        test_continuous();
        test_back_to_back();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
